// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha keystream core: FSM state encoding,
// the "expand 32-byte k" constants, and the quarter-round index tables.
package chacha_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    COPY  = 3'd1,
    CALC  = 3'd2,
    SUM   = 3'd3,
    READY = 3'd4,
    INC   = 3'd5
  } state_e;

  localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  // Column rounds: word indices (a, b, c, d) for quarter-round 0..3.
  localparam logic [3:0] QR_COL [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  // Diagonal rounds: word indices (a, b, c, d) for quarter-round 0..3.
  localparam logic [3:0] QR_DIAG [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  // 32-bit left rotate; n is always in 1..31 at the call sites.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    rotl32 = (x << n) | (x >> (32'd32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round (add / xor / rotate by 16, 12, 8, 7).
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] a1_s;
  logic [31:0] b1_s;
  logic [31:0] c1_s;
  logic [31:0] d1_s;

  // Two ARX half-steps chained in one cycle.
  always_comb begin
    a1_s = a_i + b_i;
    d1_s = rotl32(d_i ^ a1_s, 32'd16);
    c1_s = c_i + d1_s;
    b1_s = rotl32(b_i ^ c1_s, 32'd12);
    a_o  = a1_s + b1_s;
    d_o  = rotl32(d1_s ^ a_o, 32'd8);
    c_o  = c1_s + d_o;
    b_o  = rotl32(b1_s ^ c_o, 32'd7);
  end

endmodule

// File: rtl/chacha_keystream.sv
// ChaCha keystream core. The host streams in the 16-word input block, the core
// runs ROUNDS rounds (one quarter round per cycle), adds the input block and
// streams out 64 keystream bytes; after the last read it bumps the block
// counter and recomputes. Optional macro CHACHA_XOR_EN: XOR data_in into
// data_out on reads for in-line encryption.
module chacha_keystream
  import chacha_pkg::*;
#(
  parameter int ROUNDS    = 20,
  parameter int IO_W      = 8,
  parameter int COUNTER_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IO_W-1:0] data_in,
  input  logic            write,
  input  logic            read,
  output logic [IO_W-1:0] data_out,
  output logic            ready,
  output logic            busy,
  output logic            ctr_wrap
);

  localparam int NW  = 512 / IO_W;
  localparam int PER = 32 / IO_W;
  localparam int PW  = $clog2(NW);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NW - 1);
  localparam logic [4:0]    ROUND_LAST = 5'(ROUNDS - 1);
  localparam logic [31:0]   LANE_MASK  = (IO_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << IO_W) - 32'd1);
  localparam logic [63:0]   CTR_MASK   = (COUNTER_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

  state_e        state_q, state_d;
  logic [31:0]   in_q [16];
  logic [31:0]   in_d [16];
  logic [31:0]   wk_q [16];
  logic [31:0]   wk_d [16];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    round_q, round_d;
  logic [1:0]    qr_q, qr_d;
  logic          ctr_wrap_q, ctr_wrap_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic [3:0]      sel_s [4];
  logic [31:0]     qa_s, qb_s, qc_s, qd_s;
  int              wr_word_s, wr_sh_s, rd_word_s, rd_sh_s;
  logic [IO_W-1:0] ks_slice_s;
  logic [63:0]     ctr_old_s, ctr_new_s;

  // Pick the quarter-round operands: columns on even rounds, diagonals on odd.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (round_q[0]) begin
        sel_s[i] = QR_DIAG[qr_q][i];
      end else begin
        sel_s[i] = QR_COL[qr_q][i];
      end
    end
  end

  chacha_qr u_qr (
    .a_i (wk_q[sel_s[0]]),
    .b_i (wk_q[sel_s[1]]),
    .c_i (wk_q[sel_s[2]]),
    .d_i (wk_q[sel_s[3]]),
    .a_o (qa_s),
    .b_o (qb_s),
    .c_o (qc_s),
    .d_o (qd_s)
  );

  // Little-endian transfer addressing: word index and bit offset inside the word.
  always_comb begin
    wr_word_s  = int'(wr_ptr_q) / PER;
    wr_sh_s    = (int'(wr_ptr_q) % PER) * IO_W;
    rd_word_s  = int'(rd_ptr_q) / PER;
    rd_sh_s    = (int'(rd_ptr_q) % PER) * IO_W;
    ks_slice_s = IO_W'(wk_q[rd_word_s] >> rd_sh_s);
  end

  // Keystream (or ciphertext) output; forced to zero whenever no block is ready.
  always_comb begin
    if (ready_q) begin
`ifdef CHACHA_XOR_EN
      if (read) begin
        data_out = ks_slice_s ^ data_in;
      end else begin
        data_out = ks_slice_s;
      end
`else
      data_out = ks_slice_s;
`endif
    end else begin
      data_out = {IO_W{1'b0}};
    end
  end

  // FSM next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    in_d       = in_q;
    wk_d       = wk_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    round_d    = round_q;
    qr_d       = qr_q;
    ctr_wrap_d = ctr_wrap_q;
    ctr_old_s  = {in_q[13], in_q[12]} & CTR_MASK;
    ctr_new_s  = (ctr_old_s + 64'd1) & CTR_MASK;
    case (state_q)
      LOAD: begin
        if (write) begin
          in_d[wr_word_s] = (in_q[wr_word_s] & ~(LANE_MASK << wr_sh_s)) | (32'(data_in) << wr_sh_s);
          ctr_wrap_d = 1'b0;
          if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_d = {PW{1'b0}};
            state_d  = COPY;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      COPY: begin
        wk_d    = in_q;
        state_d = CALC;
      end
      CALC: begin
        wk_d[sel_s[0]] = qa_s;
        wk_d[sel_s[1]] = qb_s;
        wk_d[sel_s[2]] = qc_s;
        wk_d[sel_s[3]] = qd_s;
        if (qr_q == 2'd3) begin
          qr_d = 2'd0;
          if (round_q == ROUND_LAST) begin
            round_d = 5'd0;
            state_d = SUM;
          end else begin
            round_d = round_q + 5'd1;
          end
        end else begin
          qr_d = qr_q + 2'd1;
        end
      end
      SUM: begin
        for (int i = 0; i < 16; i++) begin
          wk_d[i] = wk_q[i] + in_q[i];
        end
        state_d = READY;
      end
      READY: begin
        if (write) begin
          // A new load aborts the read stream; this transfer is word 0, lane 0.
          in_d[0]    = (in_q[0] & ~LANE_MASK) | 32'(data_in);
          rd_ptr_d   = {PW{1'b0}};
          wr_ptr_d   = PW'(1);
          ctr_wrap_d = 1'b0;
          state_d    = LOAD;
        end else if (read) begin
          if (rd_ptr_q == PTR_LAST) begin
            rd_ptr_d = {PW{1'b0}};
            state_d  = INC;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end else begin
          state_d = READY;
        end
      end
      INC: begin
        in_d[12] = ctr_new_s[31:0];
        if (COUNTER_W == 64) begin
          in_d[13] = ctr_new_s[63:32];
        end else begin
          in_d[13] = in_q[13];
        end
        if (ctr_old_s == CTR_MASK) begin
          ctr_wrap_d = 1'b1;
        end else begin
          ctr_wrap_d = ctr_wrap_q;
        end
        state_d = COPY;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    ready_d = (state_d == READY);
    busy_d  = (state_d == COPY) || (state_d == CALC) || (state_d == SUM) || (state_d == INC);
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      round_q    <= 5'd0;
      qr_q       <= 2'd0;
      ctr_wrap_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        in_q[i] <= 32'd0;
        wk_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      round_q    <= round_d;
      qr_q       <= qr_d;
      ctr_wrap_q <= ctr_wrap_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      in_q       <= in_d;
      wk_q       <= wk_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign ctr_wrap = ctr_wrap_q;

endmodule

// File: tb/tb_chacha_keystream.sv
// Directed bench for chacha_keystream: a ChaCha20/8-bit instance and a
// ChaCha8/32-bit/64-bit-counter instance, checked against RFC 8439 bytes and
// a small software model of the block function.
module tb_chacha_keystream;
  import chacha_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CHACHA_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic        rst_na, wr_a, rd_a, rdy_a, busy_a, wrap_a;
  logic [7:0]  din_a, dout_a;
  logic        rst_nb, wr_b, rd_b, rdy_b, busy_b, wrap_b;
  logic [31:0] din_b, dout_b;

  chacha_keystream #(.ROUNDS(20), .IO_W(8), .COUNTER_W(32)) dut_a (
    .clk(clk), .rst_n(rst_na), .data_in(din_a), .write(wr_a), .read(rd_a),
    .data_out(dout_a), .ready(rdy_a), .busy(busy_a), .ctr_wrap(wrap_a)
  );

  chacha_keystream #(.ROUNDS(8), .IO_W(32), .COUNTER_W(64)) dut_b (
    .clk(clk), .rst_n(rst_nb), .data_in(din_b), .write(wr_b), .read(rd_b),
    .data_out(dout_b), .ready(rdy_b), .busy(busy_b), .ctr_wrap(wrap_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] blk   [16];
  logic [31:0] m_x   [16];
  logic [31:0] m_out [16];
  logic [31:0] got_w [16];
  int          cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- software reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr_m(input logic [31:0] a, b, c, d);
    a = a + b; d = rl(d ^ a, 16);
    c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);
    c = c + d; b = rl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  task automatic mqr(input int a, input int b, input int c, input int d);
    logic [127:0] r;
    r = qr_m(m_x[a], m_x[b], m_x[c], m_x[d]);
    m_x[a] = r[127:96]; m_x[b] = r[95:64]; m_x[c] = r[63:32]; m_x[d] = r[31:0];
  endtask

  task automatic model(input int rounds);
    for (int i = 0; i < 16; i++) m_x[i] = blk[i];
    for (int r = 0; r < rounds; r += 2) begin
      mqr(0, 4, 8, 12); mqr(1, 5, 9, 13); mqr(2, 6, 10, 14); mqr(3, 7, 11, 15);
      mqr(0, 5, 10, 15); mqr(1, 6, 11, 12); mqr(2, 7, 8, 13); mqr(3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) m_out[i] = m_x[i] + blk[i];
  endtask

  // RFC 8439 key 00..1f, nonce 000000090000004a00000000, chosen counter words.
  task automatic set_blk(input logic [31:0] w12, input logic [31:0] w13);
    for (int i = 0; i < 4; i++) blk[i] = SIGMA[i];
    for (int i = 0; i < 8; i++) blk[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    blk[12] = w12;
    blk[13] = w13;
    blk[14] = 32'h4a000000;
    blk[15] = 32'h00000000;
  endtask

  task automatic cmp_model(input string tag);
    for (int i = 0; i < 16; i++) check_eq($sformatf("%s_w%0d", tag, i), got_w[i], m_out[i]);
  endtask

  // ---------------- instance A (8-bit bus) ----------------
  task automatic load_a(input int first);
    for (int k = first; k < 64; k++) begin
      @(negedge clk);
      wr_a  = 1'b1;
      din_a = 8'(blk[k/4] >> (8*(k%4)));
    end
    @(negedge clk);
    wr_a  = 1'b0;
    din_a = 8'h00;
  endtask

  task automatic wait_ready_a(input int start, output int n);
    n = start;
    while (rdy_a !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_a(input logic [7:0] pat);
    for (int k = 0; k < 64; k++) begin
      rd_a  = 1'b1;
      din_a = pat;
      #1;
      got_w[k/4][8*(k%4) +: 8] = dout_a ^ (XOR_EN ? pat : 8'h00);
      @(negedge clk);
    end
    rd_a  = 1'b0;
    din_a = 8'h00;
  endtask

  // ---------------- instance B (32-bit bus) ----------------
  task automatic load_b();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      wr_b  = 1'b1;
      din_b = blk[k];
    end
    @(negedge clk);
    wr_b  = 1'b0;
    din_b = 32'd0;
  endtask

  task automatic wait_ready_b(input int start, output int n);
    n = start;
    while (rdy_b !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_b();
    for (int k = 0; k < 16; k++) begin
      rd_b = 1'b1;
      #1;
      got_w[k] = dout_b;
      @(negedge clk);
    end
    rd_b = 1'b0;
  endtask

  initial begin
    rst_na = 1'b0; wr_a = 1'b0; rd_a = 1'b0; din_a = 8'h00;
    rst_nb = 1'b0; wr_b = 1'b0; rd_b = 1'b0; din_b = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", rdy_a, 1'b0);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_wrap", wrap_a, 1'b0);
    check_eq("rst_dout", dout_a, 8'h00);
    rst_na = 1'b1;
    rst_nb = 1'b1;
    @(negedge clk);

    // RFC 8439 2.3.2 block, counter = 1
    set_blk(32'd1, 32'h09000000);
    model(20);
    load_a(0);
    wait_ready_a(0, cnt);
    check_eq("lat_load", 64'(cnt), 64'd82);
    check_eq("first_byte", dout_a, 8'h10);
    read_a(8'h00);
    check_eq("rfc_w0", got_w[0], 32'he4e7f110);
    check_eq("rfc_w1", got_w[1], 32'h15593bd1);
    cmp_model("rfc");
    check_eq("rdy_drop", rdy_a, 1'b0);
    check_eq("busy_inc", busy_a, 1'b1);

    // Automatic recompute with counter = 2 (data_in = FF while reading)
    blk[12] = 32'd2;
    model(20);
    wait_ready_a(0, cnt);
    check_eq("lat_read", 64'(cnt), 64'd83);
    read_a(8'hFF);
    cmp_model("ctr2");

    // Reset in mid-CALC: outputs drop immediately
    repeat (20) @(negedge clk);
    check_eq("calc_busy", busy_a, 1'b1);
    #2 rst_na = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy_a, 1'b0);
    check_eq("mid_rst_ready", rdy_a, 1'b0);
    check_eq("mid_rst_dout", dout_a, 8'h00);
    @(negedge clk);
    rst_na = 1'b1;

    // Reload; writes during COPY/CALC must be ignored
    blk[12] = 32'd1;
    model(20);
    load_a(0);
    repeat (10) begin
      wr_a  = 1'b1;
      din_a = 8'hAA;
      @(negedge clk);
    end
    wr_a  = 1'b0;
    din_a = 8'h00;
    wait_ready_a(10, cnt);
    check_eq("lat_reload", 64'(cnt), 64'd82);
    read_a(8'h00);
    check_eq("reload_w0", got_w[0], 32'he4e7f110);
    cmp_model("reload");

    // write + read together in READY: write wins, becomes transfer 0 of new load
    wait_ready_a(0, cnt);
    check_eq("lat_read2", 64'(cnt), 64'd83);
    set_blk(32'hFFFFFFFF, 32'h09000000);
    model(20);
    wr_a  = 1'b1;
    rd_a  = 1'b1;
    din_a = blk[0][7:0];
    @(negedge clk);
    wr_a  = 1'b0;
    rd_a  = 1'b0;
    check_eq("abort_ready", rdy_a, 1'b0);
    check_eq("abort_busy", busy_a, 1'b0);
    load_a(1);
    wait_ready_a(0, cnt);
    check_eq("lat_abort", 64'(cnt), 64'd82);
    check_eq("wrap_before", wrap_a, 1'b0);
    read_a(8'h00);
    cmp_model("wrapblk");

    // 32-bit counter wrap: sticky flag, word 13 untouched
    repeat (2) @(negedge clk);
    check_eq("wrap_set", wrap_a, 1'b1);
    blk[12] = 32'd0;
    model(20);
    wait_ready_a(2, cnt);
    check_eq("lat_wrap", 64'(cnt), 64'd83);
    read_a(8'h00);
    cmp_model("ctr0");
    check_eq("wrap_sticky", wrap_a, 1'b1);
    wait_ready_a(0, cnt);
    set_blk(32'd1, 32'h09000000);
    load_a(0);
    check_eq("wrap_cleared", wrap_a, 1'b0);

    // ChaCha8, 32-bit bus, 64-bit counter carry into word 13
    set_blk(32'hFFFFFFFF, 32'h00000007);
    model(8);
    load_b();
    wait_ready_b(0, cnt);
    check_eq("b_lat_load", 64'(cnt), 64'd34);
    read_b();
    cmp_model("c8");
    repeat (2) @(negedge clk);
    check_eq("b_nowrap", wrap_b, 1'b0);
    blk[12] = 32'd0;
    blk[13] = 32'd8;
    model(8);
    wait_ready_b(2, cnt);
    check_eq("b_lat_read", 64'(cnt), 64'd35);
    read_b();
    cmp_model("c8carry");

    // 64-bit counter all ones wraps to zero
    wait_ready_b(0, cnt);
    set_blk(32'hFFFFFFFF, 32'hFFFFFFFF);
    model(8);
    load_b();
    wait_ready_b(0, cnt);
    read_b();
    cmp_model("c8max");
    repeat (2) @(negedge clk);
    check_eq("b_wrap", wrap_b, 1'b1);
    blk[12] = 32'd0;
    blk[13] = 32'd0;
    model(8);
    wait_ready_b(2, cnt);
    read_b();
    cmp_model("c8zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
